reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 32-bit RISC-V integer register file. It sits directly upstream of the ALU and supplies both ALU operands: rs1 data drives i_a, and rs2 data drives i_b when there is no immediate.
- Two combinational read ports, one synchronous write port and one combinational debug read port.
- x0 is hardwired to zero. x2 (sp) has a programmable reset value.
- Optional write-to-read bypass makes a same-cycle write visible on the read ports.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.
- SP_RESET, 32'h0000_0000, reset value loaded into x2.
- BYPASS, 1, 1 = read ports forward i_rd_data on an address match with an active write; 0 = read ports show only stored state.

Ports:
- i_clk  input  1  clock; all register updates occur on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rs1_addr  input  ADDR_WIDTH  source register 1 index.
- i_rs2_addr  input  ADDR_WIDTH  source register 2 index.
- o_rs1_data  output  DATA_WIDTH  rs1 read data (to ALU i_a).
- o_rs2_data  output  DATA_WIDTH  rs2 read data (to ALU i_b / store data).
- i_rd_we  input  1  write enable for the destination register.
- i_rd_addr  input  ADDR_WIDTH  destination register index.
- i_rd_data  input  DATA_WIDTH  write-back data (ALU o_c, load data, or PC+4).
- i_dbg_addr  input  ADDR_WIDTH  debug/testbench read index.
- o_dbg_data  output  DATA_WIDTH  debug read data; stored state only, never bypassed.

Behaviour:
- Reset: one clock; i_rst_n is asynchronous and active-low.
  - i_rst_n low immediately sets every register to 0, except x2, which is set to SP_RESET.
  - The reset takes effect without waiting for a clock edge.
  - Writes are ignored while i_rst_n is low.
- Reads: purely combinational, zero latency.
  - Reading index 0 always returns 0 on every port, including during a write to index 0.
  - Outputs are not registered, so their "reset value" is the reset contents: 0 for every index except 2, which returns SP_RESET.
- Write: on the rising edge of i_clk, when i_rst_n is high, i_rd_we = 1 and i_rd_addr != 0, reg[i_rd_addr] <= i_rd_data.
  - Writes to x0 are discarded; x0 is never stored.
  - The new value is visible on the read ports in the cycle after the edge.
- Bypass (BYPASS = 1): if i_rd_we = 1, i_rd_addr != 0 and i_rd_addr == i_rsN_addr, then o_rsN_data = i_rd_data in the same cycle.
  - Both read ports may bypass at the same time when both match.
  - With BYPASS = 0, the read ports show the old value until the edge.
- Debug port: always shows stored state and ignores bypass, so verification observes committed architectural state.
- Reset mid-operation:
  - An edge where i_rst_n is low does not write.
  - A write on the first rising edge after i_rst_n deasserts is accepted normally; no recovery cycle is inserted.
  - Bypass is inhibited while i_rst_n is low, so read ports show reset contents.
- Width rules:
  - All index values 0..31 are valid; there is no out-of-range case.
  - Data is stored verbatim with no sign handling. Sign interpretation belongs to the ALU.

Test Plan:
1. Reset: assert i_rst_n = 0 mid-cycle with SP_RESET = 32'h0001_0000 -> without waiting for a clock edge, o_dbg_data reads 0 for every index except x2 = 32'h0001_0000.
2. Write then read: write x5 = 32'hDEAD_BEEF and x6 = 32'h0000_0007 on consecutive edges. Then set rs1 = 5, rs2 = 6 -> o_rs1_data = 32'hDEAD_BEEF, o_rs2_data = 32'h0000_0007. Feed both to the ALU ADD op -> sum 32'hDEAD_BEF6.
3. x0 immutability: write x0 = 32'hFFFF_FFFF with we = 1, and set rs1 = rs2 = dbg = 0 -> all three outputs stay 0 before and after the edge, with BYPASS = 1.
4. Bypass: x7 holds 32'h1111_1111; in the same cycle present we = 1, rd = 7, data = 32'h2222_2222, rs1 = rs2 = 7 -> both read ports show 32'h2222_2222 before the edge and o_dbg_data (dbg = 7) shows 32'h1111_1111. Repeat with BYPASS = 0 -> the read ports show 32'h1111_1111 until the edge.
5. we = 0 hold: present rd = 9, data = 32'hABCD_0123, we = 0 for 3 edges -> x9 stays at its prior value, 0.
6. Reset mid-write: x4 = 32'h5; drive we = 1, rd = 4, data = 32'h9, and pull i_rst_n low before the edge -> x4 = 0 after that edge. Release reset and write x4 = 32'h9 on the next edge -> x4 = 32'h9.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit RISC-V integer register file.
// Two combinational read ports, one synchronous write port and one debug read port.
// x0 reads as zero, x2 (sp) resets to SP_RESET, and an optional bypass
// forwards a same-cycle write to the read ports.
module reg_file #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0,
  parameter bit                    BYPASS     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  input  logic                  i_rd_we,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SP_IDX = 2;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic                  wr_en;
  logic                  bypass_en;
  logic [DATA_WIDTH-1:0] rs1_stored;
  logic [DATA_WIDTH-1:0] rs2_stored;

  // A write commits only to a non-zero destination; x0 is never stored.
  assign wr_en = i_rd_we && (i_rd_addr != '0);

  // Forwarding is suppressed during reset so the read ports show reset contents.
  assign bypass_en = BYPASS && i_rst_n && wr_en;

  // Next-state of the register array: hold everything, then apply the write.
  always_comb begin
    // NOTE: every element gets its default before the conditional write, so
    // no path leaves regs_d unassigned and no latch is inferred.
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (wr_en) begin
      regs_d[i_rd_addr] = i_rd_data;
    end
  end

  // Register array update with asynchronous reset to architectural reset values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the array is reset deliberately -- x2 must come up as SP_RESET
      // and all other registers as zero, so this is architectural state, not
      // scratch RAM, and it uses non-blocking assignments like all state.
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Stored-state reads; index 0 is forced to zero independently of storage.
  assign rs1_stored = (i_rs1_addr == '0) ? '0 : regs_q[i_rs1_addr];
  assign rs2_stored = (i_rs2_addr == '0) ? '0 : regs_q[i_rs2_addr];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];

  // Read ports with optional same-cycle write forwarding.
  assign o_rs1_data = (bypass_en && (i_rd_addr == i_rs1_addr)) ? i_rd_data : rs1_stored;
  assign o_rs2_data = (bypass_en && (i_rd_addr == i_rs2_addr)) ? i_rd_data : rs2_stored;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed test of reg_file with an architectural model.
// Two instances share stimulus: one with bypass enabled and one without.
`timescale 1ns/1ps
module tb_reg_file;

  localparam logic [31:0] SP = 32'h0001_0000;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic        rd_we;
  logic [31:0] rd_data;
  logic [31:0] rs1_b, rs2_b, dbg_b;
  logic [31:0] rs1_n, rs2_n, dbg_n;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [31:0] model [32];

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_RESET(SP), .BYPASS(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_data(rs1_b), .o_rs2_data(rs2_b),
    .i_rd_we(rd_we), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_RESET(SP), .BYPASS(1'b0)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_data(rs1_n), .o_rs2_data(rs2_n),
    .i_rd_we(rd_we), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural state: committed registers, reset values on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 2) ? SP : 32'h0;
    end else if (rd_we && rd_addr != 0) begin
      model[rd_addr] = rd_data;
    end
  end

  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 0) ? 32'h0 : model[a];
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a);
    if (rst_n && rd_we && rd_addr != 0 && rd_addr == a) return rd_data;
    return stored(a);
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_rs1_byp", rs1_b, fwd(rs1_addr));
      check("cyc_rs2_byp", rs2_b, fwd(rs2_addr));
      check("cyc_dbg_byp", dbg_b, stored(dbg_addr));
      check("cyc_rs1_nobyp", rs1_n, stored(rs1_addr));
      check("cyc_rs2_nobyp", rs2_n, stored(rs2_addr));
      check("cyc_dbg_nobyp", dbg_n, stored(dbg_addr));
    end
  end

  // Advance to 2 ns after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    rd_we = we; rd_addr = rd; rd_data = d;
    rs1_addr = r1; rs2_addr = r2; dbg_addr = dbg;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    cmp_on = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Reset contents through all ports.
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd3, 5'd2);
    #1;
    check("rst_rs1_x2", rs1_b, SP);
    check("rst_rs2_x3", rs2_b, 32'h0);
    check("rst_dbg_x2", dbg_b, SP);

    // Write then read, fed into an ALU add.
    step(); drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    step(); drive(1'b1, 5'd6, 32'h0000_0007, 5'd0, 5'd0, 5'd0);
    step(); drive(1'b1, 5'd2, 32'h0000_1234, 5'd5, 5'd6, 5'd2);
    #1;
    check("wr_rs1_x5", rs1_b, 32'hDEAD_BEEF);
    check("wr_rs2_x6", rs2_b, 32'h0000_0007);
    check("alu_add", rs1_b + rs2_b, 32'hDEAD_BEF6);
    step(); drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd2);
    #1;
    check("wr_dbg_x2", dbg_b, 32'h0000_1234);

    // Asynchronous reset mid-cycle, observed before any clock edge.
    step();
    dbg_addr = 5'd5;
    #1 rst_n = 1'b0;
    #1;
    check("async_dbg_x5", dbg_b, 32'h0);
    dbg_addr = 5'd2;
    #0.5;
    check("async_dbg_x2", dbg_b, SP);
    check("async_dbg_x2_nb", dbg_n, SP);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.2;
      check("rst_sweep", dbg_b, (i == 2) ? SP : 32'h0);
    end
    step();
    rst_n = 1'b1;

    // x0 immutability with a write to index 0.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_rs1_pre", rs1_b, 32'h0);
    check("x0_rs2_pre", rs2_b, 32'h0);
    check("x0_dbg_pre", dbg_b, 32'h0);
    step(); drive(1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_rs1_post", rs1_b, 32'h0);
    check("x0_dbg_post", dbg_b, 32'h0);

    // Bypass versus stored-only reads.
    step(); drive(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0, 5'd0);
    step(); drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 5'd7);
    #1;
    check("byp_rs1", rs1_b, 32'h2222_2222);
    check("byp_rs2", rs2_b, 32'h2222_2222);
    check("byp_dbg", dbg_b, 32'h1111_1111);
    check("nobyp_rs1", rs1_n, 32'h1111_1111);
    check("nobyp_rs2", rs2_n, 32'h1111_1111);
    step(); drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7);
    #1;
    check("byp_after_rs1", rs1_b, 32'h2222_2222);
    check("nobyp_after_rs1", rs1_n, 32'h2222_2222);
    check("after_dbg", dbg_b, 32'h2222_2222);

    // we = 0 holds x9 across three edges.
    step(); drive(1'b0, 5'd9, 32'hABCD_0123, 5'd9, 5'd9, 5'd9);
    step(); step(); step();
    #1;
    check("hold_dbg_x9", dbg_b, 32'h0);
    check("hold_rs1_x9", rs1_b, 32'h0);

    // Reset arriving while a write is pending.
    drive(1'b1, 5'd4, 32'h0000_0005, 5'd0, 5'd0, 5'd4);
    step(); drive(1'b1, 5'd4, 32'h0000_0009, 5'd4, 5'd4, 5'd4);
    #1;
    check("pre_rst_dbg_x4", dbg_b, 32'h0000_0005);
    rst_n = 1'b0;
    #1;
    check("rst_byp_inhibit", rs1_b, 32'h0);
    step();
    #1;
    check("rst_edge_dbg_x4", dbg_b, 32'h0);
    rst_n = 1'b1;
    step();
    #1;
    check("post_rst_dbg_x4", dbg_b, 32'h0000_0009);
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd2, 5'd4);
    #1;
    check("post_rst_rs1_x4", rs1_b, 32'h0000_0009);
    check("post_rst_rs2_x2", rs2_b, SP);

    step(); step();
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
